eq_cmp_arbiter: RTL and testbench

- Round-robin scheduler that shares one Nbit_Equal_Comp instance among NREQ requesters, such as branch resolution and hazard/forwarding checks.
- Accepts at most one compare request per cycle over a valid/ready handshake.
- Registers the equality result together with the requester ID into a one-entry response buffer that supports backpressure.
- Sustains one compare per cycle when the response side is always ready.

---
 rtl/eq_cmp_arbiter.sv | 125 ++++++++++++
 tb/tb_eq_cmp_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_cmp_arbiter.sv
// Round-robin arbiter sharing one N-bit equality comparator among NREQ requesters,
// with a one-entry backpressured response buffer and a saturating accept counter.

module Nbit_Equal_Comp #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Eq
);
  assign Eq = (A == B);
endmodule

module eq_cmp_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [NREQ*N-1:0] ReqData0,
  input  logic [NREQ*N-1:0] ReqData1,
  output logic [NREQ-1:0]   ReqReady,
  output logic              RespValid,
  output logic [IDW-1:0]    RespId,
  output logic              RespEq,
  input  logic              RespReady,
  output logic [15:0]       CmpCount
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic           eq_q, eq_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [N-1:0]   opa [NREQ];
  logic [N-1:0]   opb [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opa[i] = ReqData0[i*N +: N];
    assign opb[i] = ReqData1[i*N +: N];
  end

  logic           can_accept;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] sel_id;
  logic           fire;
  logic           cmp_eq;

  assign can_accept = (state_q == EMPTY) || RespReady;

  // Scan from the round-robin pointer; the first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && ReqValid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  assign fire     = grant_vld && can_accept && !rst;
  assign ReqReady = fire ? (NREQ'(1) << grant_id) : '0;
  assign sel_id   = grant_vld ? grant_id : ptr_q;

  Nbit_Equal_Comp #(.N(N)) u_cmp (
    .A  (opa[sel_id]),
    .B  (opb[sel_id]),
    .Eq (cmp_eq)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    eq_d    = eq_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (fire) begin
      state_d = FULL;
      id_d    = grant_id;
      eq_d    = cmp_eq;
      ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      cnt_d   = sat_inc(cnt_q);
    end else if (state_q == FULL && RespReady) begin
      state_d = EMPTY;
    end
  end

  // Response buffer register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      id_q    <= '0;
      eq_q    <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      eq_q    <= eq_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RespValid = (state_q == FULL);
  assign RespId    = id_q;
  assign RespEq    = eq_q;
  assign CmpCount  = cnt_q;

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Scoreboard bench for eq_cmp_arbiter: a cycle-level reference model predicts grants
// and queues expected responses; a separate monitor checks every presented response.

module tb_eq_cmp_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   ReqValid;
  logic [NREQ*N-1:0] ReqData0;
  logic [NREQ*N-1:0] ReqData1;
  logic [NREQ-1:0]   ReqReady;
  logic              RespValid;
  logic [IDW-1:0]    RespId;
  logic              RespEq;
  logic              RespReady;
  logic [15:0]       CmpCount;

  eq_cmp_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ReqValid  (ReqValid),
    .ReqData0  (ReqData0),
    .ReqData1  (ReqData1),
    .ReqReady  (ReqReady),
    .RespValid (RespValid),
    .RespId    (RespId),
    .RespEq    (RespEq),
    .RespReady (RespReady),
    .CmpCount  (CmpCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           eq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mptr   = 0;
  int          mcount = 0;
  bit          mvalid = 0;
  logic [31:0] d0 [NREQ];
  logic [31:0] d1 [NREQ];
  bit          pend [NREQ];
  logic [NREQ-1:0] last_rdy;
  int          last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      ReqData0[i*N +: N] = d0[i];
      ReqData1[i*N +: N] = d1[i];
    end
  endtask

  // One clock cycle: drive, check grant at negedge, advance model at posedge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input logic r);
    int g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    pack();
    ReqValid  = v;
    RespReady = rr;
    rst       = r;
    @(negedge clk);
    g = -1;
    if (!r && (!mvalid || rr)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
    end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    last_rdy = ReqReady;
    last_g   = g;
    chk("grant", 32'(ReqReady), 32'(exp_rdy));
    chk("resp_valid", 32'(RespValid), 32'(mvalid));
    chk("cmp_count", 32'(CmpCount), 32'(mcount));
    @(posedge clk);
    if (r) begin
      mvalid = 0;
      mptr   = 0;
      mcount = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      e.id = IDW'(g);
      e.eq = (d0[g] == d1[g]);
      exp_q.push_back(e);
      mvalid = 1;
      mptr   = (g + 1) % NREQ;
      if (mcount < 65535) mcount++;
    end else if (mvalid && rr) begin
      mvalid = 0;
    end
    #1;
  endtask

  // Monitor: every held response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (RespValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got id %0d eq %0d with empty scoreboard", RespId, RespEq);
      end else begin
        if (RespId !== exp_q[0].id || RespEq !== exp_q[0].eq) begin
          errors++;
          $display("FAIL resp_data: got id %0d eq %0d expected id %0d eq %0d",
                   RespId, RespEq, exp_q[0].id, exp_q[0].eq);
        end
        if (RespReady === 1'b1 && rst === 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      d0[i] = $urandom;
      d1[i] = $urandom;
      pend[i] = 0;
    end
    pack();
    ReqValid  = '0;
    RespReady = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(RespValid), 32'd0);
    chk("reset_id", 32'(RespId), 32'd0);
    chk("reset_eq", 32'(RespEq), 32'd0);
    chk("reset_count", 32'(CmpCount), 32'd0);

    // Single equal request on requester 0
    d0[0] = 32'h01234567; d1[0] = 32'h01234567;
    cycle(4'b0001, 1'b1, 1'b0);
    chk("single_rdy", 32'(last_rdy), 32'h1);
    chk("single_valid", 32'(RespValid), 32'd1);
    chk("single_id", 32'(RespId), 32'd0);
    chk("single_eq", 32'(RespEq), 32'd1);
    chk("single_count", 32'(CmpCount), 32'd1);

    // Off-by-one inequalities on requester 2
    d0[2] = 32'h01234567; d1[2] = 32'h01234568;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("neq_plus_id", 32'(RespId), 32'd2);
    chk("neq_plus_eq", 32'(RespEq), 32'd0);
    d1[2] = 32'h01234566;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("neq_minus_eq", 32'(RespEq), 32'd0);
    d0[2] = 32'h00000000; d1[2] = 32'h00000001;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("neq_zero_eq", 32'(RespEq), 32'd0);

    // Round robin starting right after a fire on requester 3
    cycle(4'b1000, 1'b1, 1'b0);
    chk("rr_pre_id", 32'(RespId), 32'd3);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      chk("rr_grant", 32'(last_rdy), 32'(1 << (k % NREQ)));
    end

    // Backpressure then simultaneous drain and accept
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0010, 1'b0, 1'b0);
      chk("bp_rdy", 32'(last_rdy), 32'd0);
      chk("bp_id", 32'(RespId), 32'd0);
    end
    cycle(4'b0010, 1'b1, 1'b0);
    chk("bp_release_rdy", 32'(last_rdy), 32'h2);
    chk("bp_release_id", 32'(RespId), 32'd1);
    chk("bp_release_valid", 32'(RespValid), 32'd1);

    // Reset while a response with RespEq=1 is held
    d0[2] = 32'hCAFEF00D; d1[2] = 32'hCAFEF00D;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("pre_rst_eq", 32'(RespEq), 32'd1);
    cycle(4'b0100, 1'b0, 1'b1);
    chk("rst_rdy", 32'(last_rdy), 32'd0);
    chk("rst_valid", 32'(RespValid), 32'd0);
    chk("rst_count", 32'(CmpCount), 32'd0);
    chk("rst_eq", 32'(RespEq), 32'd0);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("rst_ptr", 32'(last_rdy), 32'h1);

    // Randomized traffic: requesters hold valid/data until granted
    for (int c = 0; c < 600; c++) begin
      logic [NREQ-1:0] v;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          d0[i] = $urandom;
          case ($urandom_range(0, 3))
            0, 1: d1[i] = d0[i];
            2:    d1[i] = d0[i] ^ (32'h1 << $urandom_range(0, 31));
            default: d1[i] = d0[i] + 32'd1;
          endcase
        end
        v[i] = pend[i];
      end
      cycle(v, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      if (last_g >= 0) pend[last_g] = 0;
    end

    // Counter saturation
    cycle(4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 65534; c++) cycle(4'b1111, 1'b1, 1'b0);
    chk("sat_fffe", 32'(CmpCount), 32'h0000FFFE);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("sat_ffff", 32'(CmpCount), 32'h0000FFFF);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("sat_hold", 32'(CmpCount), 32'h0000FFFF);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("drain_valid", 32'(RespValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
